// File: rtl/regs_mp.sv
// regs_mp: two-read one-write register array with optional zero entry, write forwarding and a clear sweep
module regs_mp #(
   parameter int REGS_WIDTH      = 8,
   parameter int REGS_WIDTH_ADDR = 4,
   parameter int REGS_ZERO       = 0,
   parameter int REGS_BYPASS     = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_wt_en,
   input  logic [REGS_WIDTH_ADDR-1:0] i_wt_addr,
   input  logic [REGS_WIDTH-1:0]      i_wt_data,
   output logic                       o_wt_ack,
   input  logic [REGS_WIDTH_ADDR-1:0] i_rd_addr_a,
   input  logic [REGS_WIDTH_ADDR-1:0] i_rd_addr_b,
   output logic [REGS_WIDTH-1:0]      o_rd_data_a,
   output logic [REGS_WIDTH-1:0]      o_rd_data_b,
   input  logic                       i_clr,
   output logic                       o_busy,
   output logic                       o_done
);
   localparam int DEPTH = 2**REGS_WIDTH_ADDR;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                     state_q, state_d;
   logic [REGS_WIDTH_ADDR-1:0] cnt_q;
   logic                       done_q;
   logic                       last;
   logic                       drop;
   logic [REGS_WIDTH-1:0]      mem [DEPTH];
   assign last     = cnt_q == '1;
   assign drop     = (REGS_ZERO != 0) && (i_wt_addr == '0);
   assign o_wt_ack = i_wt_en && (state_q == IDLE) && !i_clr;
   assign o_busy   = state_q == CLEAR;
   assign o_done   = done_q;
   always_comb begin
      state_d = (state_q == IDLE) ? (i_clr ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
         done_q  <= (state_q == CLEAR) && last;
      end
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end else if (o_wt_ack && !drop) begin
         mem[i_wt_addr] <= i_wt_data;
      end
   end
   // zero entry wins over forwarding; reset forces reads to zero regardless of the write port
   assign o_rd_data_a = (i_rst || ((REGS_ZERO != 0) && i_rd_addr_a == '0)) ? '0 :
                        ((REGS_BYPASS != 0) && o_wt_ack && i_wt_addr == i_rd_addr_a) ? i_wt_data :
                        mem[i_rd_addr_a];
   assign o_rd_data_b = (i_rst || ((REGS_ZERO != 0) && i_rd_addr_b == '0)) ? '0 :
                        ((REGS_BYPASS != 0) && o_wt_ack && i_wt_addr == i_rd_addr_b) ? i_wt_data :
                        mem[i_rd_addr_b];
endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: scoreboard bench for regs_mp with default, no-bypass and zero-entry instances
module tb_regs_mp;
   logic       i_clk = 0, i_rst = 1, wt_en = 0, clr = 0;
   logic [3:0] wa = 0, ra = 0, rb = 0;
   logic [7:0] wd = 0;
   logic       ack_d, busy_d, done_d, ack_n, busy_n, done_n, ack_z, busy_z, done_z;
   logic [7:0] a_d, b_d, a_n, b_n, a_z, b_z;
   int         vectors = 0, miscompares = 0;
   logic [7:0] m [16];
   bit         busy_m = 0, done_m = 0;
   int         cnt_m = 0;
   string      tq[$];
   logic [7:0] eq[$];
   always #5 i_clk = ~i_clk;
   regs_mp u_def (.i_clk(i_clk), .i_rst(i_rst), .i_wt_en(wt_en), .i_wt_addr(wa), .i_wt_data(wd),
      .o_wt_ack(ack_d), .i_rd_addr_a(ra), .i_rd_addr_b(rb), .o_rd_data_a(a_d), .o_rd_data_b(b_d),
      .i_clr(clr), .o_busy(busy_d), .o_done(done_d));
   regs_mp #(.REGS_BYPASS(0)) u_nb (.i_clk(i_clk), .i_rst(i_rst), .i_wt_en(wt_en), .i_wt_addr(wa),
      .i_wt_data(wd), .o_wt_ack(ack_n), .i_rd_addr_a(ra), .i_rd_addr_b(rb), .o_rd_data_a(a_n),
      .o_rd_data_b(b_n), .i_clr(clr), .o_busy(busy_n), .o_done(done_n));
   regs_mp #(.REGS_ZERO(1)) u_z (.i_clk(i_clk), .i_rst(i_rst), .i_wt_en(wt_en), .i_wt_addr(wa),
      .i_wt_data(wd), .o_wt_ack(ack_z), .i_rd_addr_a(ra), .i_rd_addr_b(rb), .o_rd_data_a(a_z),
      .o_rd_data_b(b_z), .i_clr(clr), .o_busy(busy_z), .o_done(done_z));
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic push(input string tag, input logic [7:0] v);
      tq.push_back(tag);
      eq.push_back(v);
   endtask
   task automatic pop(input logic [7:0] got);
      if (eq.size() == 0) check("sb_underflow", got, ~got);
      else check(tq.pop_front(), got, eq.pop_front());
   endtask
   function automatic logic [7:0] rdm(input int r, input int a, input int d, input bit byp,
                                      input bit z, input bit ack);
      if (z && r == 0) return 8'h00;
      if (byp && ack && r == a) return 8'(d);
      return m[r];
   endfunction
   task automatic cyc(input bit we, input int a, input int d, input int r_a, input int r_b, input bit c);
      bit ack;
      wt_en = we; wa = 4'(a); wd = 8'(d); ra = 4'(r_a); rb = 4'(r_b); clr = c;
      ack = we && !busy_m && !c;
      push("ack", 8'(ack)); push("busy", 8'(busy_m)); push("done", 8'(done_m));
      push("rd_a", rdm(r_a, a, d, 1, 0, ack)); push("rd_b", rdm(r_b, a, d, 1, 0, ack));
      push("nb_ack", 8'(ack)); push("nb_busy", 8'(busy_m)); push("nb_done", 8'(done_m));
      push("nb_rd_a", rdm(r_a, a, d, 0, 0, ack)); push("nb_rd_b", rdm(r_b, a, d, 0, 0, ack));
      push("z_ack", 8'(ack)); push("z_done", 8'(done_m));
      push("z_rd_a", rdm(r_a, a, d, 1, 1, ack)); push("z_rd_b", rdm(r_b, a, d, 1, 1, ack));
      #4;
      pop(8'(ack_d)); pop(8'(busy_d)); pop(8'(done_d)); pop(a_d); pop(b_d);
      pop(8'(ack_n)); pop(8'(busy_n)); pop(8'(done_n)); pop(a_n); pop(b_n);
      pop(8'(ack_z)); pop(8'(done_z)); pop(a_z); pop(b_z);
      @(posedge i_clk);
      done_m = 0;
      if (busy_m) begin
         m[cnt_m] = 0;
         if (cnt_m == 15) begin
            busy_m = 0; done_m = 1; cnt_m = 0;
         end else cnt_m++;
      end else if (c) begin
         busy_m = 1; cnt_m = 0;
      end else if (ack) m[a] = 8'(d);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 16; i++) m[i] = 0;
      #2;
      check("rst_busy", 8'(busy_d), 0);
      check("rst_done", 8'(done_d), 0);
      check("rst_rd_a", a_d, 0);
      #10 i_rst = 0;
      @(posedge i_clk); #1;
      cyc(1, 3, 'hA5, 0, 0, 0);
      cyc(0, 0, 0, 3, 4, 0);
      cyc(1, 7, 'h3C, 7, 7, 0);
      cyc(1, 7, 'h5A, 7, 3, 0);
      cyc(0, 0, 0, 7, 7, 0);
      cyc(1, 0, 'hFF, 0, 0, 0);
      cyc(0, 0, 0, 0, 3, 0);
      for (int i = 0; i < 16; i++) cyc(1, i, 'h10 + i, i, (i + 15) % 16, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, i, 15 - i, 0);
      cyc(0, 0, 0, 0, 15, 1);
      for (int k = 0; k < 16; k++) cyc(1, k, 'h77, k, (k + 1) % 16, 0);
      cyc(0, 0, 0, 1, 2, 0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, i, 15 - i, 0);
      for (int i = 1; i < 5; i++) cyc(1, i, 'h20 + i, i, i, 0);
      cyc(1, 2, 'h55, 2, 2, 1);
      for (int k = 0; k < 16; k++) cyc(0, 0, 0, 2, 4, k == 8);
      cyc(0, 0, 0, 2, 3, 0);
      cyc(0, 0, 0, 2, 4, 0);
      for (int i = 0; i < 16; i++) cyc(1, i, 'hC0 + i, i, i, 0);
      cyc(0, 0, 0, 5, 6, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, k, 10, 0);
      #2 i_rst = 1;
      #1;
      check("arst_busy", 8'(busy_d), 0);
      check("arst_done", 8'(done_d), 0);
      for (int i = 0; i < 16; i++) begin
         ra = 4'(i); rb = 4'(15 - i);
         #0.1;
         check("arst_rd_a", a_d, 0);
         check("arst_rd_b", b_d, 0);
         check("arst_nb_rd_a", a_n, 0);
      end
      @(posedge i_clk); #1;
      check("arst_hold_busy", 8'(busy_d), 0);
      check("arst_hold_done", 8'(done_d), 0);
      for (int i = 0; i < 16; i++) m[i] = 0;
      busy_m = 0; done_m = 0; cnt_m = 0;
      #2 i_rst = 0;
      @(posedge i_clk); #1;
      cyc(1, 9, 'hC3, 9, 10, 0);
      cyc(0, 0, 0, 9, 10, 0);
      cyc(0, 0, 0, 11, 12, 0);
      check("sb_left", 8'(eq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regs_mp.md
REGS_MP -- requirements
Module: regs_mp

Interface
REQ-001 SHALL provide parameter REGS_WIDTH, default 8, data width of each entry in bits.
REQ-002 SHALL provide parameter REGS_WIDTH_ADDR, default 4, address width; depth = 2**REGS_WIDTH_ADDR.
REQ-003 SHALL provide parameter REGS_ZERO, default 0; 1 = entry 0 hardwired to zero.
REQ-004 SHALL provide parameter REGS_BYPASS, default 1; 1 = write-to-read forwarding enabled.
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_wt_en  input  1  write request.
REQ-008 SHALL have port i_wt_addr  input  REGS_WIDTH_ADDR  write address.
REQ-009 SHALL have port i_wt_data  input  REGS_WIDTH  write data.
REQ-010 SHALL have port o_wt_ack  output  1  write accepted this cycle (combinational).
REQ-011 SHALL have ports i_rd_addr_a / i_rd_addr_b  input  REGS_WIDTH_ADDR  read addresses, ports A/B.
REQ-012 SHALL have ports o_rd_data_a / o_rd_data_b  output  REGS_WIDTH  read data, ports A/B.
REQ-013 SHALL have port i_clr  input  1  start hardware clear sweep.
REQ-014 SHALL have port o_busy  output  1  clear sweep in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse, sweep finished.

Function
REQ-016 SHALL hold depth entries of REGS_WIDTH bits in flops; no initial file load.
REQ-017 SHALL implement states IDLE and CLEAR; IDLE -> CLEAR on i_clr=1 in IDLE; CLEAR -> IDLE after final entry cleared.
REQ-018 SHALL assert o_wt_ack = i_wt_en & (state==IDLE) & ~i_clr; only acked writes update the array, on the next rising edge.
REQ-019 SHALL drop writes when ZERO=1 and i_wt_addr==0 (ack still asserted, entry stays 0).
REQ-020 SHALL drive read ports combinationally from the array, same cycle as address; both ports independent, same address allowed.
REQ-021 SHALL, when BYPASS=1 and an acked write targets the read address in the same cycle, return i_wt_data on that read port; BYPASS=0 returns the old stored value.
REQ-022 SHALL return 0 on any read of address 0 when ZERO=1, overriding bypass.
REQ-023 SHALL, in CLEAR, zero one entry per cycle using an internal counter starting at 0, incrementing to depth-1; sweep = depth cycles.
REQ-024 SHALL hold o_busy=1 for exactly the depth cycles in CLEAR; o_busy=0 in IDLE.
REQ-025 SHALL pulse o_done=1 for one cycle, registered, in the cycle after the last entry is cleared (first IDLE cycle).
REQ-026 SHALL ignore i_clr while in CLEAR (no restart, no extension).
REQ-027 SHALL give i_clr priority over i_wt_en in the same IDLE cycle: write not acked, not performed.
REQ-028 SHALL, during CLEAR, return already-cleared entries as 0 and not-yet-cleared entries as their old values; no bypass (no acked writes).
REQ-029 SHALL wrap the sweep counter to 0 on return to IDLE.

Reset
REQ-030 SHALL, on i_rst=1, immediately clear all entries to 0, state to IDLE, counter to 0, o_busy=0, o_done=0, independent of i_clk.
REQ-031 SHALL abort any sweep in progress on reset, with no o_done pulse.
REQ-032 SHALL resume normal operation on the first rising edge after i_rst deasserts; reads during reset return 0.

Verification
REQ-033 Defaults; write 0xA5 to addr 3, next cycle read A=3 -> 0xA5; read B=4 -> 0x00.
REQ-034 BYPASS=1: write 0x3C to addr 7 while A=7 same cycle -> o_rd_data_a=0x3C before edge; BYPASS=0 -> old value.
REQ-035 ZERO=1: write 0xFF to addr 0 -> o_wt_ack=1, read addr 0 -> 0x00, including same-cycle bypass case.
REQ-036 Fill all 16 entries with 0x10+addr, pulse i_clr -> o_busy high 16 cycles, writes during sweep get o_wt_ack=0, o_done pulse on cycle 17, all reads 0x00.
REQ-037 i_clr and i_wt_en (addr 2, 0x55) same cycle -> o_wt_ack=0, addr 2 ends 0x00 after sweep; second i_clr mid-sweep -> sweep still 16 cycles.
REQ-038 Assert i_rst asynchronously mid-sweep and mid-cycle -> o_busy=0 and all reads 0x00 immediately, no o_done; write after release succeeds.
